mem_access_stage: RTL
=====================

Name: mem_access_stage

Overview:
- MEM stage of the 5-stage core. Sits between the EX/MEM pipeline register and the MEM/WB register.
- Performs load/store transactions on the data bus using a ready handshake, with byte-lane steering, load sign/zero extension and misalignment detection.
- Non-memory instructions pass straight through to MEM/WB. The block stalls the pipeline while a bus access is outstanding.

Parameters:
- ADDR_WIDTH, 32, data bus address width.
- REG_WIDTH, 5, register index width.
- DATA_WIDTH, 32, datapath width; only 32 is supported (4 byte lanes).

Ports:
- i_Clock  in  1  clock.
- i_Reset  in  1  reset; asynchronous, active-low.
- i_Valid  in  1  EX/MEM holds a valid instruction.
- i_Flush  in  1  suppress writeback of the current instruction.
- i_InstOP  in  7  opcode.
- i_Funct3  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- i_MemRdEnable  in  1  instruction is a load.
- i_MemWrEnable  in  1  instruction is a store.
- i_Addr  in  ADDR_WIDTH  effective address (ALU result).
- i_WrData  in  DATA_WIDTH  store data (rs2).
- i_RegWrAddr  in  REG_WIDTH  destination register.
- i_RegWrEnable  in  1  destination write request.
- i_AluResult  in  DATA_WIDTH  result for non-load instructions.
- o_MemAddr  out  ADDR_WIDTH  bus address.
- o_MemRdEnable  out  1  bus read request.
- o_MemWrEnable  out  1  bus write request.
- o_MemByteEnable  out  4  bus byte lanes.
- o_MemWrData  out  DATA_WIDTH  bus write data.
- i_MemRdData  in  DATA_WIDTH  bus read data, valid when i_MemReady=1.
- i_MemReady  in  1  bus completes the access this cycle.
- o_Stall  out  1  freeze IF..EX/MEM.
- o_Misaligned  out  1  misaligned access detected (1-cycle pulse).
- o_InstOP  out  7  to MEM/WB.
- o_RegWrAddr  out  REG_WIDTH  to MEM/WB.
- o_RegWrEnable  out  1  to MEM/WB.
- o_RegWrData  out  DATA_WIDTH  to MEM/WB.

Behaviour:
- FSM states: IDLE, ACCESS, DONE. Reset (i_Reset=0, asynchronous) forces IDLE.
- Reset values: all bus outputs 0, o_Stall 0, o_Misaligned 0, and all registered result fields 0.
- memop = i_Valid & (i_MemRdEnable | i_MemWrEnable).
- Misaligned when: H/HU with addr[0]=1, or W with addr[1:0]≠00. Funct3 codes 011/110/111 are treated as W.
- IDLE, non-memop:
  - Combinational pass-through: o_RegWrData=i_AluResult, o_RegWrAddr/o_InstOP from inputs.
  - o_RegWrEnable = i_Valid & i_RegWrEnable & ~i_Flush.
  - o_Stall=0.
- IDLE, memop misaligned:
  - o_Misaligned=1 combinationally; no bus request; o_RegWrEnable=0; o_Stall=0; remain in IDLE.
- IDLE, memop aligned:
  - o_Stall=1 combinationally and o_RegWrEnable=0.
  - At the clock edge, latch address, funct3, destination, opcode, byte enables, steered write data and flushed flag (=i_Flush); go to ACCESS.
- ACCESS:
  - o_MemRdEnable/o_MemWrEnable asserted from registers; address, byte enables and write data held stable.
  - o_Stall=1; o_RegWrEnable=0.
  - On a cycle where i_MemReady=1: capture the extended load result (0 for stores), drop the request on the next edge, and go to DONE.
  - i_Flush asserted while in ACCESS sets the latched flushed flag. The bus access is never aborted.
- DONE (exactly 1 cycle):
  - o_Stall=0; o_RegWrData = captured result.
  - o_RegWrEnable = latched RegWrEnable & load & ~flushed.
  - Next state IDLE.
- Access latency: request is visible 1 cycle after acceptance; result reaches MEM/WB 1 cycle after i_MemReady. Minimum stall is 2 cycles when i_MemReady is already high in ACCESS.
- Store steering, with o = addr[1:0]:
  - B: data {4{wd[7:0]}}, byte enable 0001<<o.
  - H: data {2{wd[15:0]}}, byte enable 0011<<o.
  - W: data wd, byte enable 1111.
  - Loads drive byte enable with the same masks and write data 0.
- Load extraction:
  - Shift = i_MemRdData >> (8*o).
  - B/H are sign-extended; BU/HU are zero-extended; W is used as-is.
- o_MemAddr carries the full byte address; the bus honours the byte enables.
- Reset mid-ACCESS: requests drop immediately (asynchronously), the transaction is abandoned, and no writeback occurs.

Test Plan:
- LW addr 0x100, i_MemRdData=0xDEADBEEF, ready after 3 ACCESS cycles -> o_Stall high for 4 cycles total; DONE cycle has o_RegWrData=0xDEADBEEF and o_RegWrEnable=1.
- LB addr 0x103, rd data 0x80123456 -> o_MemByteEnable=1000, o_RegWrData=0xFFFFFF80. LBU at the same address -> 0x00000080.
- SH addr 0x202, wd 0x0000ABCD, ready immediately -> o_MemByteEnable=1100, o_MemWrData=0xABCDABCD, o_MemWrEnable for 1 cycle, o_RegWrEnable=0.
- LW addr 0x101 -> o_Misaligned=1 for 1 cycle; no bus request; o_Stall=0; o_RegWrEnable=0.
- LW issued, i_Flush=1 during ACCESS -> bus read completes, but DONE has o_RegWrEnable=0.
- ADD with i_AluResult=0x1234, rd=5 -> same-cycle o_RegWrData=0x1234, o_RegWrAddr=5, o_RegWrEnable=1.
- i_Reset low mid-ACCESS -> o_MemRdEnable and o_Stall go 0 without a clock edge; FSM restarts in IDLE.

Source files
------------

// File: rtl/mem_access_stage.sv
// MEM stage: drives load/store accesses on a ready-handshake data bus, with byte-lane
// steering, load extension and misalignment detection; non-memory results pass through.
module mem_access_stage #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned REG_WIDTH  = 5,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  i_Clock,
    input  logic                  i_Reset,
    input  logic                  i_Valid,
    input  logic                  i_Flush,
    input  logic [6:0]            i_InstOP,
    input  logic [2:0]            i_Funct3,
    input  logic                  i_MemRdEnable,
    input  logic                  i_MemWrEnable,
    input  logic [ADDR_WIDTH-1:0] i_Addr,
    input  logic [DATA_WIDTH-1:0] i_WrData,
    input  logic [REG_WIDTH-1:0]  i_RegWrAddr,
    input  logic                  i_RegWrEnable,
    input  logic [DATA_WIDTH-1:0] i_AluResult,
    output logic [ADDR_WIDTH-1:0] o_MemAddr,
    output logic                  o_MemRdEnable,
    output logic                  o_MemWrEnable,
    output logic [3:0]            o_MemByteEnable,
    output logic [DATA_WIDTH-1:0] o_MemWrData,
    input  logic [DATA_WIDTH-1:0] i_MemRdData,
    input  logic                  i_MemReady,
    output logic                  o_Stall,
    output logic                  o_Misaligned,
    output logic [6:0]            o_InstOP,
    output logic [REG_WIDTH-1:0]  o_RegWrAddr,
    output logic                  o_RegWrEnable,
    output logic [DATA_WIDTH-1:0] o_RegWrData
);

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [2:0]            r_funct3;
    logic [REG_WIDTH-1:0]  r_rd;
    logic [6:0]            r_op;
    logic [3:0]            r_be;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic                  r_flushed;
    logic                  r_is_load;
    logic                  r_is_store;
    logic                  r_regwe;
    logic [DATA_WIDTH-1:0] r_result;

    logic                  w_memop;
    logic                  w_is_load;
    logic [1:0]            w_off;
    logic                  w_is_b;
    logic                  w_is_h;
    logic                  w_is_w;
    logic                  w_misaligned;
    logic [3:0]            w_be;
    logic [DATA_WIDTH-1:0] w_wdata;
    logic [DATA_WIDTH-1:0] w_shift;
    logic [DATA_WIDTH-1:0] w_load;

    // Access decode from EX/MEM; funct3[1:0] selects size, codes 011/110/111 fall into W
    assign w_memop      = i_Valid & (i_MemRdEnable | i_MemWrEnable);
    assign w_is_load    = i_MemRdEnable;
    assign w_off        = i_Addr[1:0];
    assign w_is_b       = (i_Funct3[1:0] == 2'b00);
    assign w_is_h       = (i_Funct3[1:0] == 2'b01);
    assign w_is_w       = ~(w_is_b | w_is_h);
    assign w_misaligned = (w_is_h & w_off[0]) | (w_is_w & (w_off != 2'b00));

    always_comb begin
        w_be    = 4'b1111;
        w_wdata = i_WrData;
        if (w_is_b) begin
            w_be    = 4'(4'b0001 << w_off);
            w_wdata = {4{i_WrData[7:0]}};
        end else if (w_is_h) begin
            w_be    = 4'(4'b0011 << w_off);
            w_wdata = {2{i_WrData[15:0]}};
        end
        if (w_is_load) begin
            w_wdata = '0;
        end
    end

    // Load lane extraction uses the latched offset and size
    assign w_shift = i_MemRdData >> {r_addr[1:0], 3'b000};

    always_comb begin
        w_load = w_shift;
        case (r_funct3)
            3'b000:  w_load = {{(DATA_WIDTH-8){w_shift[7]}}, w_shift[7:0]};
            3'b100:  w_load = {{(DATA_WIDTH-8){1'b0}}, w_shift[7:0]};
            3'b001:  w_load = {{(DATA_WIDTH-16){w_shift[15]}}, w_shift[15:0]};
            3'b101:  w_load = {{(DATA_WIDTH-16){1'b0}}, w_shift[15:0]};
            default: w_load = w_shift;
        endcase
    end

    // State and transaction registers
    always_ff @(posedge i_Clock or negedge i_Reset) begin
        if (!i_Reset) begin
            r_state    <= S_IDLE;
            r_addr     <= '0;
            r_funct3   <= '0;
            r_rd       <= '0;
            r_op       <= '0;
            r_be       <= '0;
            r_wdata    <= '0;
            r_flushed  <= 1'b0;
            r_is_load  <= 1'b0;
            r_is_store <= 1'b0;
            r_regwe    <= 1'b0;
            r_result   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_memop && !w_misaligned) begin
                        r_addr     <= i_Addr;
                        r_funct3   <= i_Funct3;
                        r_rd       <= i_RegWrAddr;
                        r_op       <= i_InstOP;
                        r_be       <= w_be;
                        r_wdata    <= w_wdata;
                        r_flushed  <= i_Flush;
                        r_is_load  <= w_is_load;
                        r_is_store <= ~w_is_load;
                        r_regwe    <= i_RegWrEnable;
                        r_state    <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    // A flush during the access only cancels writeback; the bus cycle completes
                    r_flushed <= r_flushed | i_Flush;
                    if (i_MemReady) begin
                        r_result <= r_is_load ? w_load : '0;
                        r_state  <= S_DONE;
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Bus requests, stall and MEM/WB outputs
    always_comb begin
        o_MemAddr       = '0;
        o_MemRdEnable   = 1'b0;
        o_MemWrEnable   = 1'b0;
        o_MemByteEnable = '0;
        o_MemWrData     = '0;
        o_Stall         = 1'b0;
        o_Misaligned    = 1'b0;
        o_InstOP        = i_InstOP;
        o_RegWrAddr     = i_RegWrAddr;
        o_RegWrEnable   = 1'b0;
        o_RegWrData     = i_AluResult;
        case (r_state)
            S_IDLE: begin
                if (w_memop) begin
                    o_Misaligned = w_misaligned;
                    o_Stall      = ~w_misaligned;
                end else begin
                    o_RegWrEnable = i_Valid & i_RegWrEnable & ~i_Flush;
                end
            end
            S_ACCESS: begin
                o_MemAddr       = r_addr;
                o_MemRdEnable   = r_is_load;
                o_MemWrEnable   = r_is_store;
                o_MemByteEnable = r_be;
                o_MemWrData     = r_wdata;
                o_Stall         = 1'b1;
                o_InstOP        = r_op;
                o_RegWrAddr     = r_rd;
                o_RegWrData     = '0;
            end
            S_DONE: begin
                o_InstOP      = r_op;
                o_RegWrAddr   = r_rd;
                o_RegWrData   = r_result;
                o_RegWrEnable = r_regwe & r_is_load & ~r_flushed;
            end
            default: ;
        endcase
    end

endmodule
